// File: rtl/ysyx_23060061_ifu_prefetch.sv
// Pipelined prefetching IFU: credit-limited sequential fetch into a FIFO queue, flushed on redirect.
// Optional feature macro IFU_PERF_CNT_EN adds pop-count and empty-stall performance counters.
module ysyx_23060061_ifu_prefetch #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst,
  output logic [ADDR_W-1:0] inst_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
`endif
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] rsp_pc_r;
  logic [XLEN-1:0]   q_inst_r [FQ_DEPTH];
  logic [ADDR_W-1:0] q_pc_r   [FQ_DEPTH];
  logic [PW-1:0]     wptr_r;
  logic [PW-1:0]     rptr_r;
  logic [CW-1:0]     q_count_r;
  logic [CW-1:0]     outstanding_r;
  logic [CW-1:0]     drop_cnt_r;
  logic [XLEN-1:0]   last_inst_r;
  logic [ADDR_W-1:0] last_pc_r;
  logic              run_r;

  logic [CW-1:0]     credits_s;
  logic [CW-1:0]     outstanding_nxt_s;
  logic              req_fire_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;

  // Queued entries plus in-flight requests never exceed the queue size, so responses need no back-pressure.
  assign credits_s         = q_count_r + outstanding_r;
  assign mem_req_valid     = run_r && !redirect_valid && (credits_s < DEPTH_C);
  assign mem_req_addr      = fetch_pc_r;
  assign req_fire_s        = mem_req_valid && mem_req_ready;
  assign pop_s             = inst_valid && inst_ready;
  assign push_s            = mem_rsp_valid && (drop_cnt_r == {CW{1'b0}});
  assign drop_s            = mem_rsp_valid && (drop_cnt_r != {CW{1'b0}});
  assign outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(mem_rsp_valid);

  // An empty queue keeps presenting the most recently consumed entry.
  assign inst_valid = (q_count_r != {CW{1'b0}});
  assign inst       = inst_valid ? q_inst_r[rptr_r] : last_inst_r;
  assign inst_pc    = inst_valid ? q_pc_r[rptr_r]   : last_pc_r;

  // Fetch, response and queue state; a redirect overrides everything except the pop bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      wptr_r        <= {PW{1'b0}};
      rptr_r        <= {PW{1'b0}};
      q_count_r     <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
      last_inst_r   <= {XLEN{1'b0}};
      last_pc_r     <= {ADDR_W{1'b0}};
      run_r         <= 1'b0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_inst_r[i] <= {XLEN{1'b0}};
        q_pc_r[i]   <= {ADDR_W{1'b0}};
      end
    end else begin
      run_r         <= 1'b1;
      outstanding_r <= outstanding_nxt_s;
      if (pop_s) begin
        last_inst_r <= q_inst_r[rptr_r];
        last_pc_r   <= q_pc_r[rptr_r];
      end
      if (redirect_valid) begin
        // Every request still in flight after this cycle belongs to the old stream.
        fetch_pc_r <= redirect_pc;
        rsp_pc_r   <= redirect_pc;
        drop_cnt_r <= outstanding_nxt_s;
        wptr_r     <= {PW{1'b0}};
        rptr_r     <= {PW{1'b0}};
        q_count_r  <= {CW{1'b0}};
      end else begin
        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + STEP_C;
        end
        if (drop_s) begin
          drop_cnt_r <= drop_cnt_r - CW'(1'b1);
        end
        if (push_s) begin
          q_inst_r[wptr_r] <= mem_rsp_data;
          q_pc_r[wptr_r]   <= rsp_pc_r;
          wptr_r           <= wptr_r + PW'(1'b1);
          rsp_pc_r         <= rsp_pc_r + STEP_C;
        end
        if (pop_s) begin
          rptr_r <= rptr_r + PW'(1'b1);
        end
        q_count_r <= q_count_r + CW'(push_s) - CW'(pop_s);
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters survive redirects and wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
      perf_stall_cnt <= 64'd0;
    end else begin
      if (pop_s) begin
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      end
      if (inst_ready && !inst_valid) begin
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060061_ifu_prefetch.sv
// Self-checking bench for ysyx_23060061_ifu_prefetch: in-order memory model plus a stream-level
// reference (expected fetch address and expected delivered pc, both restarted by redirects).
module tb_ysyx_23060061_ifu_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ysyx_23060061_ifu_prefetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          cyc, last_due, lat_min, lat_max;
  logic [31:0] exp_fetch, exp_pop;
  int          n_checks, n_fail, n_req, n_pop, n_stall;
  logic        s_req_valid, s_req_fire, s_inst_valid, s_pop;
  logic [31:0] s_req_addr, s_inst, s_inst_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: present memory response, sample outputs, update the stream reference.
  task automatic step();
    mreq_t r;
    int    lat;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      r = memq.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(r.addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    #1;
    s_req_valid  = mem_req_valid;
    s_req_addr   = mem_req_addr;
    s_inst_valid = inst_valid;
    s_inst       = inst;
    s_inst_pc    = inst_pc;
    s_req_fire   = s_req_valid && mem_req_ready;
    s_pop        = s_inst_valid && inst_ready;
    if (!rst) begin
      if (redirect_valid) begin
        n_checks++;
        if (s_req_valid !== 1'b0) begin
          n_fail++; $display("FAIL req_during_redirect cyc=%0d got valid=%b want 0", cyc, s_req_valid);
        end
      end
      if (s_req_fire) begin
        n_checks++;
        if (s_req_addr !== exp_fetch) begin
          n_fail++; $display("FAIL fetch_addr cyc=%0d got %h want %h", cyc, s_req_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
        n_req++;
        lat   = int'($urandom_range(lat_max, lat_min));
        r.addr = s_req_addr;
        r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = r.due;
        memq.push_back(r);
        n_checks++;
        if (memq.size() > DEPTH) begin
          n_fail++; $display("FAIL inflight cyc=%0d got %0d want <=%0d", cyc, memq.size(), DEPTH);
        end
      end
      if (s_pop) begin
        n_checks++;
        if (s_inst_pc !== exp_pop || s_inst !== mem_word(exp_pop)) begin
          n_fail++; $display("FAIL pop cyc=%0d got pc=%h inst=%h want pc=%h inst=%h",
                             cyc, s_inst_pc, s_inst, exp_pop, mem_word(exp_pop));
        end
        exp_pop += 32'd4;
        n_pop++;
      end
      if (inst_ready && !s_inst_valid) n_stall++;
      if (redirect_valid) begin
        exp_fetch = redirect_pc;
        exp_pop   = redirect_pc;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b1;
    inst_ready     = 1'b0;
    mem_rsp_valid  = 1'b0;
    memq.delete();
    last_due  = 0;
    exp_fetch = 32'h8000_0000;
    exp_pop   = 32'h8000_0000;
    repeat (2) step();
    rst = 1'b0;
    n_req = 0; n_pop = 0; n_stall = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; mem_req_ready = 1'b1;
    inst_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valids got req=%b inst=%b want 0 0", mem_req_valid, inst_valid);
    end
    n_checks++;
    if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs got inst=%h pc=%h want 0 0", inst, inst_pc);
    end
    do_reset();
    step();
    n_checks++;
    if (s_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_cycle got req_valid=%b want 0", s_req_valid);
    end
    step();
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL reset_first_req got %b/%h want 1/80000000", s_req_valid, s_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat_min = 1; lat_max = 1; inst_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      n_checks++;
      if (s_inst_valid !== (c >= 3)) begin
        n_fail++; $display("FAIL stream_valid c=%0d got %b want %b", c, s_inst_valid, (c >= 3));
      end
    end
    n_checks++;
    if (n_pop != 11) begin
      n_fail++; $display("FAIL stream_pops got %0d want 11", n_pop);
    end
  endtask

  task automatic test_full();
    bit got;
    do_reset();
    lat_min = 1; lat_max = 1; inst_ready = 1'b0;
    repeat (10) step();
    n_checks++;
    if (n_req != DEPTH) begin
      n_fail++; $display("FAIL full_reqs got %0d want %0d", n_req, DEPTH);
    end
    n_checks++;
    if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_state got req=%b inst=%b want 0 1", s_req_valid, s_inst_valid);
    end
    inst_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (s_req_fire && !got) begin
        got = 1'b1;
        n_checks++;
        if (s_req_addr !== 32'h8000_0010) begin
          n_fail++; $display("FAIL full_resume got %h want 80000010", s_req_addr);
        end
      end
    end
    n_checks++;
    if (!got || n_pop < 4) begin
      n_fail++; $display("FAIL full_drain got resumed=%b pops=%0d want 1 >=4", got, n_pop);
    end
  endtask

  task automatic test_redirect_drop();
    int first;
    do_reset();
    lat_min = 3; lat_max = 3; inst_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (s_inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL drop_pre_valid c=%0d got %b want 0", c, s_inst_valid);
      end
    end
    n_checks++;
    if (n_req != 3) begin
      n_fail++; $display("FAIL drop_outstanding got %0d want 3", n_req);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    step();
    redirect_valid = 1'b0;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_inst_valid && first < 0) begin
        first = c;
        n_checks++;
        if (s_inst_pc !== 32'h8000_1000) begin
          n_fail++; $display("FAIL drop_first_pc got %h want 80001000", s_inst_pc);
        end
      end
    end
    n_checks++;
    if (first != 4) begin
      n_fail++; $display("FAIL drop_first_cycle got %0d want 4", first);
    end
  endtask

  task automatic test_redirect_rsp_pop();
    int pops;
    do_reset();
    lat_min = 1; lat_max = 1; inst_ready = 1'b1;
    repeat (6) step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (s_pop !== 1'b1) begin
      n_fail++; $display("FAIL rrp_pop got %b want 1", s_pop);
    end
    step();
    n_checks++;
    if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_2000) begin
      n_fail++; $display("FAIL rrp_next got inst_valid=%b req=%b addr=%h want 0 1 80002000",
                         s_inst_valid, s_req_valid, s_req_addr);
    end
    pops = n_pop;
    repeat (8) step();
    n_checks++;
    if (exp_pop !== 32'h8000_2000 + 32'd4 * 32'(n_pop - pops) || n_pop - pops < 4) begin
      n_fail++; $display("FAIL rrp_resume got pops=%0d next=%h want >=4", n_pop - pops, exp_pop);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    int k;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    do_reset();
    lat_min = 2; lat_max = 2; inst_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_req_fire && k < 3) begin
        n_checks++;
        if (s_req_addr !== want[k]) begin
          n_fail++; $display("FAIL wrap_addr%0d got %h want %h", k, s_req_addr, want[k]);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 3) begin
      n_fail++; $display("FAIL wrap_count got %0d want 3", k);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      mem_req_ready  = ($urandom % 4) != 0;
      inst_ready     = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 40) == 0;
      redirect_pc    = ($urandom % 8 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      step();
    end
    redirect_valid = 1'b0;
    n_checks++;
    if (n_pop < 100) begin
      n_fail++; $display("FAIL random_progress got %0d pops want >=100", n_pop);
    end
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 300; i++) begin
      mem_req_ready  = ($urandom % 3) != 0;
      inst_ready     = ($urandom % 2) != 0;
      redirect_valid = ($urandom % 30) == 0;
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      step();
    end
    redirect_valid = 1'b0;
    n_checks++;
    if (perf_fetch_cnt !== 64'(n_pop) || perf_stall_cnt !== 64'(n_stall)) begin
      n_fail++; $display("FAIL perf got fetch=%0d stall=%0d want %0d %0d",
                         perf_fetch_cnt, perf_stall_cnt, n_pop, n_stall);
    end
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; lat_min = 1; lat_max = 1;
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_rsp_pop();
    test_wrap();
    test_random();
`ifdef IFU_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
